// File: rtl/sign_extend_pkg.sv
// Shared types and default widths for the decode-stage immediate extender.
package sign_extend_pkg;

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_WORD  = 2'b11
  } ext_mode_e;

endpackage

// File: rtl/sign_extend_ext_core.sv
// Combinational immediate extension: sign, zero, upper-half or word-offset.
module ext_core
  import sign_extend_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_W,
  parameter int unsigned OUT_W = WORD_W
) (
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  extend,
  output logic [OUT_W-1:0] result_c
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  ext_mode_e        mode_e;

  assign mode_e = ext_mode_e'(mode);
  assign sext   = {{PAD_W{extend[IN_W-1]}}, extend};

  // Every 2-bit encoding is a legal mode, so the result is never X.
  always_comb begin
    result_c = sext;
    case (mode_e)
      EXT_SIGN:  result_c = sext;
      EXT_ZERO:  result_c = {{PAD_W{1'b0}}, extend};
      EXT_UPPER: result_c = {extend, {PAD_W{1'b0}}};
      EXT_WORD:  result_c = {sext[OUT_W-3:0], 2'b00};
      default:   result_c = sext;
    endcase
  end

endmodule

// File: rtl/sign_extend.sv
// Registered immediate extender: one-cycle latency with a valid flag.
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_W,
  parameter int unsigned OUT_W = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  extend,
  output logic [OUT_W-1:0] extended,
  output logic             out_valid
);

  logic [OUT_W-1:0] result_c;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .mode     (mode),
    .extend   (extend),
    .result_c (result_c)
  );

  // Result register holds its value across idle cycles; valid pulses per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      extended  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) extended <= result_c;
    end
  end

endmodule

// File: tb/tb_sign_extend.sv
// Scoreboard bench for sign_extend: expected words queued on drive, checked on output.
module tb_sign_extend;
  import sign_extend_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  mode;
  logic [15:0] extend;
  logic [31:0] extended;
  logic        out_valid;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q[$];

  sign_extend dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .extend    (extend),
    .extended  (extended),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge; valid beats enqueue their expected result.
  task automatic drive(input logic v, input ext_mode_e m, input logic [15:0] e,
                       input logic [31:0] exp);
    @(negedge clk);
    in_valid = v;
    mode     = m;
    extend   = e;
    if (v) exp_q.push_back(exp);
  endtask

  // Output monitor: out_valid must track the queue and each result must match its entry.
  always @(posedge clk) begin
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    if (out_valid && exp_q.size() != 0) chk("extended", extended, exp_q.pop_front());
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    mode     = EXT_SIGN;
    extend   = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst_extended", extended, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    drive(1'b1, EXT_SIGN,  16'h00FF, 32'h000000FF);
    drive(1'b1, EXT_SIGN,  16'h80FF, 32'hFFFF80FF);
    drive(1'b1, EXT_SIGN,  16'h7FFF, 32'h00007FFF);
    drive(1'b1, EXT_SIGN,  16'h0000, 32'h00000000);
    drive(1'b1, EXT_SIGN,  16'h8000, 32'hFFFF8000);
    drive(1'b1, EXT_SIGN,  16'hFFFF, 32'hFFFFFFFF);
    drive(1'b1, EXT_ZERO,  16'h80FF, 32'h000080FF);
    drive(1'b1, EXT_UPPER, 16'h80FF, 32'h80FF0000);
    drive(1'b1, EXT_WORD,  16'hFFFF, 32'hFFFFFFFC);
    drive(1'b1, EXT_WORD,  16'h0004, 32'h00000010);
    drive(1'b1, EXT_WORD,  16'h8000, 32'hFFFE0000);
    drive(1'b0, EXT_SIGN,  16'h0000, 32'h0);

    for (int i = 0; i < 8; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      drive(1'b1, ext_mode_e'(i[1:0]), r,
            (i[1:0] == 2'd0) ? {{16{r[15]}}, r} :
            (i[1:0] == 2'd1) ? {16'h0, r} :
            (i[1:0] == 2'd2) ? {r, 16'h0} : {{14{r[15]}}, r, 2'b00});
    end

    drive(1'b1, EXT_SIGN, 16'h0001, 32'h00000001);
    drive(1'b1, EXT_SIGN, 16'hFFFE, 32'hFFFFFFFE);
    drive(1'b1, EXT_SIGN, 16'h8000, 32'hFFFF8000);
    drive(1'b1, EXT_SIGN, 16'h7FFF, 32'h00007FFF);
    drive(1'b0, EXT_ZERO, 16'hAAAA, 32'h0);
    drive(1'b0, EXT_UPPER, 16'h5555, 32'h0);
    chk("hold_valid", {31'd0, out_valid}, 32'h0);
    chk("hold_value", extended, 32'h00007FFF);

    drive(1'b1, EXT_ZERO, 16'h1234, 32'h00001234);
    drive(1'b1, EXT_ZERO, 16'h5678, 32'h00005678);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_extended", extended, 32'h0);
    chk("async_rst_valid", {31'd0, out_valid}, 32'h0);
    repeat (2) @(negedge clk);
    chk("async_rst_hold", extended, 32'h0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b1, EXT_UPPER, 16'h0001, 32'h00010000);
    drive(1'b0, EXT_SIGN,  16'h0000, 32'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sign_extend.md
Name: sign_extend

Overview:
Immediate-extension unit for the datapath's decode stage. It widens a 16-bit instruction immediate to a 32-bit operand using sign, zero, upper-half (LUI) or word-offset (branch) extension. The result is registered with a one-cycle latency and a valid flag, and feeds the ALU operand mux and the branch-target adder.

Parameters:
- IN_W, 16, input immediate width (must be ≥2 and < OUT_W).
- OUT_W, 32, output width (must be ≥ IN_W+2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies extend/mode in the current cycle.
- mode  in  2  extension mode: 00 SIGN, 01 ZERO, 10 UPPER, 11 WORD.
- extend  in  IN_W  raw immediate.
- extended  out  OUT_W  registered extended value.
- out_valid  out  1  high in the cycle when extended holds a result captured from an in_valid cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): extended=0 and out_valid=0 immediately. They stay 0 until the first rising edge after deassertion.
- Latency is 1 cycle. On a rising edge with in_valid=1, capture f(mode, extend) into extended and set out_valid=1.
- On a rising edge with in_valid=0: extended holds its previous value and out_valid=0.
- SIGN: extended = {(OUT_W-IN_W){extend[IN_W-1]}, extend}.
- ZERO: extended = {(OUT_W-IN_W){1'b0}, extend}.
- UPPER: extended = extend << (OUT_W-IN_W). For the defaults this is {extend, 16'h0000}.
- WORD: extended = sign-extended value << 2. Bits shifted out at the top are discarded, bits [1:0] are 0, and the MSB still reflects extend[IN_W-1].
- Sign boundaries for SIGN:
  - extend=0x7FFF gives 0x00007FFF.
  - extend=0x8000 gives 0xFFFF8000.
  - extend=0xFFFF gives 0xFFFFFFFF.
- Back-to-back in_valid cycles give one result per cycle, with no bubbles.
- An rst_n assertion mid-stream discards the pending result, and out_valid drops asynchronously.
- No X propagation: mode is fully decoded and has no default-to-X branch.

Decomposition:
- Shared package sign_extend_pkg holds:
  - typedef ext_mode_e (2-bit enum: EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_WORD);
  - the default widths IMM_W=16 and WORD_W=32.
- One combinational sub-module, ext_core, computes f(mode, extend). The top sign_extend holds only the output register and the valid register.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and extend=0x1234 → extended=0x00000000 and out_valid=0. Release, then one edge with in_valid=1, mode=SIGN, extend=0x00FF → extended=0x000000FF, out_valid=1.
- SIGN negative: extend=0x80FF, mode=SIGN → 0xFFFF80FF one cycle later. Also extend=0x7FFF → 0x00007FFF, and extend=0x0000 → 0x00000000.
- ZERO/UPPER: extend=0x80FF with mode=ZERO → 0x000080FF. Same extend with mode=UPPER → 0x80FF0000.
- WORD: extend=0xFFFF → 0xFFFFFFFC; extend=0x0004 → 0x00000010; extend=0x8000 → 0xFFFE0000.
- Streaming and hold:
  - Apply 4 consecutive valid inputs (0x0001, 0xFFFE, 0x8000, 0x7FFF) in SIGN mode → outputs 0x00000001, 0xFFFFFFFE, 0xFFFF8000, 0x00007FFF on consecutive cycles.
  - Then drop in_valid → out_valid=0 and extended stays at 0x00007FFF.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 → extended=0 and out_valid=0 before the next edge.
